// File: rtl/nibble_adder_sched.sv
// Two-requester wide adder that time-shares one 4-bit ripple slice, one nibble per cycle,
// LSB first, with a round-robin arbiter choosing whose operands to accept.
module nibble_adder_sched #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [4*WORDS-1:0] req0_a,
    input  logic [4*WORDS-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [4*WORDS-1:0] req1_a,
    input  logic [4*WORDS-1:0] req1_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [4*WORDS-1:0] res_sum,
    output logic               res_carry,
    output logic               res_id
);
    localparam int W     = 4 * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic       grant;
    logic       accept_en;
    logic [3:0] a_nib, b_nib, s_nib;
    logic       c_out;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid;
    end

    assign accept_en  = (state_q == ST_IDLE) && !rst;
    assign req0_ready = accept_en && req0_valid && !grant;
    assign req1_ready = accept_en && req1_valid &&  grant;

    // Shared slice: four full-adder cells rippling from the stored carry.
    always_comb begin : slice
        logic c;
        a_nib = a_q[{cnt_q, 2'b00} +: 4];
        b_nib = b_q[{cnt_q, 2'b00} +: 4];
        c     = carry_q;
        for (int i = 0; i < 4; i++) begin
            s_nib[i] = a_nib[i] ^ b_nib[i] ^ c;
            c        = (a_nib[i] & b_nib[i]) | (c & (a_nib[i] ^ b_nib[i]));
        end
        c_out = c;
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d          = grant ? req1_a : req0_a;
                    b_d          = grant ? req1_b : req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = '0;
                    carry_d      = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[{cnt_q, 2'b00} +: 4] = s_nib;
                carry_d = c_out;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == ST_DONE);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_nibble_adder_sched.sv
// Self-checking bench for nibble_adder_sched: directed cases plus randomized operations
// compared against a plain-arithmetic round-robin reference model.
module tb_nibble_adder_sched;
    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_carry, res_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_grant_m;

    nibble_adder_sched #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one unit after a rising edge with the request inputs already driven and
    // the block expected to be idle. Checks arbitration, latency, result and backpressure.
    task automatic run_op(input bit keep, input bit scramble, input int bp);
        bit           exp_g;
        logic [W:0]   exp;
        int           lat;
        logic [W-1:0] hold_sum;
        logic         hold_c, hold_id;
        exp_g = (req0_valid && req1_valid) ? ~last_grant_m : req1_valid;
        exp   = exp_g ? ({1'b0, req1_a} + {1'b0, req1_b})
                      : ({1'b0, req0_a} + {1'b0, req0_b});
        #1;
        check("req0_ready", req0_ready, !exp_g);
        check("req1_ready", req1_ready, exp_g);
        last_grant_m = exp_g;
        tick();
        if (!keep) begin
            if (exp_g) req1_valid = 1'b0;
            else       req0_valid = 1'b0;
        end
        if (scramble) begin
            req0_a = ~req0_a;
            req0_b = W'($urandom);
            req1_a = ~req1_a;
            req1_b = W'($urandom);
        end
        lat = 0;
        while (!res_valid && lat < 3 * WORDS) begin
            check("busy_ready", {req0_ready, req1_ready}, 2'b00);
            tick();
            lat++;
        end
        check("latency", lat, WORDS);
        check("res_sum", res_sum, exp[W-1:0]);
        check("res_carry", res_carry, exp[W]);
        check("res_id", res_id, exp_g);
        hold_sum = res_sum;
        hold_c   = res_carry;
        hold_id  = res_id;
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_valid", res_valid, 1'b1);
            check("bp_hold", {hold_id, hold_c, hold_sum}, {res_id, res_carry, res_sum});
            check("bp_ready", {req0_ready, req1_ready}, 2'b00);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_clr", res_valid, 1'b0);
    endtask

    task automatic drive(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
    endtask

    initial begin
        logic [1:0] sel;
        rst       = 1'b1;
        res_ready = 1'b0;
        drive(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002);
        last_grant_m = 1'b1;
        repeat (2) tick();
        check("rst_valid", res_valid, 1'b0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_sum", res_sum, 16'h0000);
        check("rst_carry_id", {res_carry, res_id}, 2'b00);
        rst = 1'b0;

        // Tie from reset: both held valid, grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) run_op(1, 0, 0);
        drive(0, '0, '0, 0, '0, '0);

        drive(1, 16'h1234, 16'h4321, 0, '0, '0);
        run_op(0, 0, 0);
        drive(0, '0, '0, 1, 16'hFFFF, 16'h0001);
        run_op(0, 0, 0);
        drive(0, '0, '0, 1, 16'h0FFF, 16'h0001);
        run_op(0, 0, 0);

        // Operands change after accept; result must use the latched ones.
        drive(1, 16'hA5A5, 16'h1111, 0, '0, '0);
        run_op(0, 1, 0);

        // Backpressure with the loser pending, then the loser accepted right away.
        drive(1, 16'h8000, 16'h8000, 1, 16'h7777, 16'h0009);
        run_op(0, 0, 3);
        run_op(0, 0, 0);
        drive(0, '0, '0, 0, '0, '0);

        // Reset while cnt==2: abandoned, no result, arbiter priority restored.
        drive(0, '0, '0, 1, 16'h3333, 16'h3333);
        #1;
        check("mr_accept", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mr_valid", res_valid, 1'b0);
        check("mr_ready", {req0_ready, req1_ready}, 2'b00);
        tick();
        rst = 1'b0;
        last_grant_m = 1'b1;
        for (int i = 0; i < WORDS + 2; i++) begin
            tick();
            check("mr_no_result", res_valid, 1'b0);
        end
        drive(1, 16'h00FF, 16'h0001, 1, 16'h0042, 16'h0001);
        run_op(0, 0, 0);
        run_op(0, 0, 0);
        drive(0, '0, '0, 0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(1, 3));
            drive(sel[0], W'($urandom), W'($urandom), sel[1], W'($urandom), W'($urandom));
            run_op(0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            drive(0, '0, '0, 0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
